// File: rtl/pooling_pkg.sv
// Shared types and helpers for the max-pooling slice: float word type, FSM state, width helper.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pooling_pkg;

    localparam int DATA_WIDTH        = `DATA_WIDTH;
    localparam int DEF_INPUT_SIZE    = 6;
    localparam int DEF_KERNEL_SIZE   = 2;
    localparam int DEF_TOTAL_FEATURE = 4;
    localparam int POOL_SIZE         = DEF_INPUT_SIZE / DEF_KERNEL_SIZE;

    typedef logic [DATA_WIDTH-1:0] float_t;

    typedef struct packed {
        logic                  sign;
        logic [DATA_WIDTH-2:0] mag;
    } float_fields_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bits needed to index 0..value-1; never less than one bit.
    function automatic int logb2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/float_max_cmp.sv
// Combinational float32 maximum; ties keep the stored operand, +0 beats -0 via the sign rule.
module float_max_cmp
    import pooling_pkg::*;
(
    input  float_t stored,
    input  float_t incoming,
    output float_t max_val
);

    float_fields_t s_f;
    float_fields_t i_f;
    logic          take_incoming;

    assign s_f = stored;
    assign i_f = incoming;

    // NOTE: every path assigns take_incoming, so no latch is inferred.
    always_comb begin
        if (s_f.sign != i_f.sign) begin
            take_incoming = s_f.sign;
        end else if (!s_f.sign) begin
            take_incoming = (i_f.mag > s_f.mag);
        end else begin
            take_incoming = (i_f.mag < s_f.mag);
        end
    end

    assign max_val = take_incoming ? incoming : stored;

endmodule

// File: rtl/pooling_max_unit.sv
// Streaming KxK max-pooling over interleaved features with a per-feature line buffer.
// Optional build macro POOLING_RELU_EN clamps negative pooled words to zero.
module pooling_max_unit
    import pooling_pkg::*;
#(
    parameter int INPUT_SIZE    = DEF_INPUT_SIZE,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int TOTAL_FEATURE = DEF_TOTAL_FEATURE
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         start,
    input  logic [`DATA_WIDTH-1:0]                       data_in,
    input  logic                                         input_valid,
    output logic [logb2(TOTAL_FEATURE)-1:0]              feature_idx,
    output logic [logb2(INPUT_SIZE)-1:0]                 feature_row,
    output logic [logb2(INPUT_SIZE/KERNEL_SIZE)-1:0]     pool_col,
    output logic [`DATA_WIDTH-1:0]                       data_out,
    output logic                                         output_valid,
    output logic                                         frame_done
);

    localparam int POOL_N = INPUT_SIZE / KERNEL_SIZE;
    localparam int F_W    = logb2(TOTAL_FEATURE);
    localparam int C_W    = logb2(INPUT_SIZE);
    localparam int P_W    = logb2(POOL_N);

    state_t         state;
    logic [F_W-1:0] f_cnt;
    logic [C_W-1:0] c_cnt;
    logic [C_W-1:0] r_cnt;

    float_t hmax [TOTAL_FEATURE];
    float_t vbuf [TOTAL_FEATURE][POOL_N];

    logic           accept;
    logic [F_W-1:0] cur_f;
    logic [C_W-1:0] cur_c;
    logic [C_W-1:0] cur_r;
    logic [P_W-1:0] cur_p;
    logic           first_col;
    logic           last_col;
    logic           first_row;
    logic           last_row;
    logic           last_f;
    logic           last_c;
    logic           frame_last;

    float_t h_stored;
    float_t h_max;
    float_t h_next;
    float_t v_stored;
    float_t v_max;
    float_t v_next;
    float_t emit_word;

    // A start pulse re-bases the position to pixel (0,0,f=0) for a same-cycle word.
    assign accept = input_valid && (start || state == RUN);
    assign cur_f  = start ? '0 : f_cnt;
    assign cur_c  = start ? '0 : c_cnt;
    assign cur_r  = start ? '0 : r_cnt;
    assign cur_p  = P_W'(int'(cur_c) / KERNEL_SIZE);

    assign first_col  = (int'(cur_c) % KERNEL_SIZE) == 0;
    assign last_col   = (int'(cur_c) % KERNEL_SIZE) == KERNEL_SIZE - 1;
    assign first_row  = (int'(cur_r) % KERNEL_SIZE) == 0;
    assign last_row   = (int'(cur_r) % KERNEL_SIZE) == KERNEL_SIZE - 1;
    assign last_f     = (cur_f == F_W'(TOTAL_FEATURE - 1));
    assign last_c     = (cur_c == C_W'(INPUT_SIZE - 1));
    assign frame_last = last_f && last_c && (cur_r == C_W'(INPUT_SIZE - 1));

    assign h_stored = hmax[cur_f];
    assign v_stored = vbuf[cur_f][cur_p];

    float_max_cmp u_h_cmp (
        .stored   (h_stored),
        .incoming (data_in),
        .max_val  (h_max)
    );

    assign h_next = first_col ? data_in : h_max;

    float_max_cmp u_v_cmp (
        .stored   (v_stored),
        .incoming (h_next),
        .max_val  (v_max)
    );

    assign v_next = first_row ? h_next : v_max;

`ifdef POOLING_RELU_EN
    assign emit_word = v_next[DATA_WIDTH-1] ? '0 : v_next;
`else
    assign emit_word = v_next;
`endif

    // NOTE: hmax/vbuf are small register arrays that must read as zero after reset,
    // so they sit in the async-reset block instead of being inferred as RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < TOTAL_FEATURE; f++) begin
                hmax[f] <= '0;
                for (int p = 0; p < POOL_N; p++) begin
                    vbuf[f][p] <= '0;
                end
            end
            output_valid <= 1'b0;
            data_out     <= '0;
            feature_idx  <= '0;
            feature_row  <= '0;
            pool_col     <= '0;
        end else begin
            output_valid <= accept && last_col && last_row;
            if (accept) begin
                hmax[cur_f] <= h_next;
                if (last_col) begin
                    vbuf[cur_f][cur_p] <= v_next;
                end
                if (last_col && last_row) begin
                    data_out    <= emit_word;
                    feature_idx <= cur_f;
                    feature_row <= cur_r;
                    pool_col    <= cur_p;
                end
            end
        end
    end

    // NOTE: state and counters use non-blocking assignments so every read above sees
    // the pre-edge value within the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            f_cnt      <= '0;
            c_cnt      <= '0;
            r_cnt      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == DONE);
            if (accept) begin
                if (frame_last) begin
                    f_cnt <= '0;
                    c_cnt <= '0;
                    r_cnt <= '0;
                    state <= DONE;
                end else begin
                    state <= RUN;
                    if (!last_f) begin
                        f_cnt <= cur_f + 1'b1;
                        c_cnt <= cur_c;
                        r_cnt <= cur_r;
                    end else if (!last_c) begin
                        f_cnt <= '0;
                        c_cnt <= cur_c + 1'b1;
                        r_cnt <= cur_r;
                    end else begin
                        f_cnt <= '0;
                        c_cnt <= '0;
                        r_cnt <= cur_r + 1'b1;
                    end
                end
            end else if (start) begin
                f_cnt <= '0;
                c_cnt <= '0;
                r_cnt <= '0;
                state <= RUN;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end

endmodule
